// File: rtl/bsg_channel_narrow_vr.sv
// Wide-to-narrow valid/ready channel: one registered wide word out as N beats.
// Optional first_o/last_o beat markers: define BSG_CHANNEL_NARROW_VR_LAST_EN.
module bsg_channel_narrow_vr #(
    parameter int width_in_p   = 16,
    parameter int width_out_p  = 8,
    parameter int lsb_to_msb_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_in_p-1:0]  data_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [width_out_p-1:0] data_o,
    output logic                   v_o,
    input  logic                   ready_i
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
    ,
    output logic                   last_o,
    output logic                   first_o
`endif
);

    localparam int rem_lp = (width_out_p == 0) ? 1 : (width_in_p % width_out_p);
    localparam int els_lp = (width_out_p == 0) ? 1 : (width_in_p / width_out_p);
    localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(els_lp - 1);

    if (width_out_p == 0 || rem_lp != 0) begin : g_bad_width
        $error("width_in_p must be a nonzero multiple of width_out_p");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                r_state;
    state_e                w_state_n;
    logic [width_in_p-1:0] r_data;
    logic [cnt_w_lp-1:0]   r_count;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_load;

    assign w_last = (r_count == last_cnt_lp);
    assign w_xfer = v_o & ready_i;
    assign w_load = ready_o & v_i;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_state_n;
    end

    // Next state: stay busy across words when a new one arrives on the last beat
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: if (v_i) w_state_n = BUSY;
            BUSY: if (w_xfer && w_last && !v_i) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Handshake outputs; ready_o opens on the last beat for gapless streaming
    always_comb begin
        v_o     = 1'b0;
        ready_o = 1'b1;
        unique case (r_state)
            IDLE: begin
                v_o     = 1'b0;
                ready_o = 1'b1;
            end
            BUSY: begin
                v_o     = 1'b1;
                ready_o = w_last & ready_i;
            end
            default: begin
                v_o     = 1'b0;
                ready_o = 1'b1;
            end
        endcase
    end

    // Word register and beat counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_data  <= data_i;
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    if (els_lp == 1) begin : g_one
        assign data_o = r_data[width_out_p-1:0];
    end else begin : g_many
        logic [els_lp-1:0][width_out_p-1:0] w_slices;
        logic [cnt_w_lp-1:0]                w_idx;
        assign w_slices = r_data;
        assign w_idx    = (lsb_to_msb_p != 0) ? r_count : (last_cnt_lp - r_count);
        assign data_o   = w_slices[w_idx];
    end

`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
    assign last_o  = v_o & w_last;
    assign first_o = v_o & (r_count == '0);
`endif

endmodule

// File: tb/tb_bsg_channel_narrow_vr.sv
// Scoreboard bench for bsg_channel_narrow_vr: 16->8 lsb-first,
// 32->8 msb-first and 32->8 lsb-first instances.
module tb_bsg_channel_narrow_vr;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [15:0] d_data_i = '0;
    logic        d_v_i = 1'b0;
    logic        d_ready_i = 1'b1;
    logic        d_ready_o;
    logic [7:0]  d_data_o;
    logic        d_v_o;

    logic [31:0] q_data_i = '0;
    logic        q_v_i = 1'b0;
    logic        q_ready_i = 1'b1;
    logic        q_ready_o;
    logic [7:0]  q_data_o;
    logic        q_v_o;

    logic [31:0] l_data_i = '0;
    logic        l_v_i = 1'b0;
    logic        l_ready_i = 1'b1;
    logic        l_ready_o;
    logic [7:0]  l_data_o;
    logic        l_v_o;

`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
    logic q_last, q_first, d_last, d_first, l_last, l_first;
`endif

    logic [7:0] d_q[$];
    logic [7:0] q_q[$];
    logic [7:0] l_q[$];

    bsg_channel_narrow_vr #(.width_in_p(16), .width_out_p(8), .lsb_to_msb_p(1)) u_d (
        .clk_i(clk), .reset_i(reset_i), .data_i(d_data_i), .v_i(d_v_i),
        .ready_o(d_ready_o), .data_o(d_data_o), .v_o(d_v_o), .ready_i(d_ready_i)
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
        , .last_o(d_last), .first_o(d_first)
`endif
    );

    bsg_channel_narrow_vr #(.width_in_p(32), .width_out_p(8), .lsb_to_msb_p(0)) u_q (
        .clk_i(clk), .reset_i(reset_i), .data_i(q_data_i), .v_i(q_v_i),
        .ready_o(q_ready_o), .data_o(q_data_o), .v_o(q_v_o), .ready_i(q_ready_i)
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
        , .last_o(q_last), .first_o(q_first)
`endif
    );

    bsg_channel_narrow_vr #(.width_in_p(32), .width_out_p(8), .lsb_to_msb_p(1)) u_l (
        .clk_i(clk), .reset_i(reset_i), .data_i(l_data_i), .v_i(l_v_i),
        .ready_o(l_ready_o), .data_o(l_data_o), .v_o(l_v_o), .ready_i(l_ready_i)
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
        , .last_o(l_last), .first_o(l_first)
`endif
    );

    // Beat monitors: compare each transferred beat against the scoreboard
    always @(negedge clk) begin
        if (!reset_i && d_v_o && d_ready_i) begin
            checks++;
            if (d_q.size() == 0) begin
                errors++;
                $display("FAIL d16_beat unexpected beat %h", d_data_o);
            end else begin
                logic [7:0] e;
                e = d_q.pop_front();
                if (d_data_o !== e) begin
                    errors++;
                    $display("FAIL d16_beat got %h expected %h", d_data_o, e);
                end
            end
        end
        if (!reset_i && q_v_o && q_ready_i) begin
            checks++;
            if (q_q.size() == 0) begin
                errors++;
                $display("FAIL q32_beat unexpected beat %h", q_data_o);
            end else begin
                logic [7:0] e;
                e = q_q.pop_front();
                if (q_data_o !== e) begin
                    errors++;
                    $display("FAIL q32_beat got %h expected %h", q_data_o, e);
                end
            end
        end
        if (!reset_i && l_v_o && l_ready_i) begin
            checks++;
            if (l_q.size() == 0) begin
                errors++;
                $display("FAIL l32_beat unexpected beat %h", l_data_o);
            end else begin
                logic [7:0] e;
                e = l_q.pop_front();
                if (l_data_o !== e) begin
                    errors++;
                    $display("FAIL l32_beat got %h expected %h", l_data_o, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_v_o, q_v_o, l_v_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_v_o got %b expected 000", {d_v_o, q_v_o, l_v_o});
        end
        checks++;
        if ({d_ready_o, q_ready_o, l_ready_o} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_o got %b expected 111",
                     {d_ready_o, q_ready_o, l_ready_o});
        end
        checks++;
        if (d_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_o got %h expected 00", d_data_o);
        end
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
        checks++;
        if ({q_first, q_last} !== 2'b00) begin
            errors++;
            $display("FAIL reset_first_last got %b expected 00", {q_first, q_last});
        end
`endif
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (d_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL release_ready_o got %b expected 1", d_ready_o);
        end
    endtask

    task automatic test_single();
        cyc();
        d_v_i = 1'b1;
        d_data_i = 16'hA55A;
        d_q.push_back(8'h5A);
        d_q.push_back(8'hA5);
        cyc();
        d_v_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_v_o, d_ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL single_beat0 v_o,ready_o got %b expected 10", {d_v_o, d_ready_o});
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({d_v_o, d_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL single_beat1 v_o,ready_o got %b expected 11", {d_v_o, d_ready_o});
        end
        cyc();
        @(negedge clk);
        checks++;
        if (d_v_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle v_o got %b expected 0", d_v_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0101;
        cyc();
        d_v_i = 1'b1;
        d_data_i = 16'h1234;
        d_q.push_back(8'h34);
        d_q.push_back(8'h12);
        d_q.push_back(8'hCD);
        d_q.push_back(8'hAB);
        cyc();
        d_data_i = 16'hABCD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({d_v_o, d_ready_o} !== {1'b1, exp_rdy[3-k]}) begin
                errors++;
                $display("FAIL b2b_beat%0d v_o,ready_o got %b expected %b",
                         k, {d_v_o, d_ready_o}, {1'b1, exp_rdy[3-k]});
            end
            cyc();
            if (k == 1) d_v_i = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (d_v_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle v_o got %b expected 0", d_v_o);
        end
    endtask

    task automatic test_ratio4_msb();
        cyc();
        q_v_i = 1'b1;
        q_data_i = 32'h01020304;
        q_q.push_back(8'h01);
        q_q.push_back(8'h02);
        q_q.push_back(8'h03);
        q_q.push_back(8'h04);
        cyc();
        q_v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({q_v_o, q_ready_o} !== {1'b1, (k == 3)}) begin
                errors++;
                $display("FAIL r4_beat%0d v_o,ready_o got %b expected %b",
                         k, {q_v_o, q_ready_o}, {1'b1, (k == 3)});
            end
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
            checks++;
            if ({q_first, q_last} !== {(k == 0), (k == 3)}) begin
                errors++;
                $display("FAIL r4_first_last%0d got %b expected %b",
                         k, {q_first, q_last}, {(k == 0), (k == 3)});
            end
`endif
            cyc();
        end
        @(negedge clk);
        checks++;
        if (q_v_o !== 1'b0) begin
            errors++;
            $display("FAIL r4_idle v_o got %b expected 0", q_v_o);
        end
`ifdef BSG_CHANNEL_NARROW_VR_LAST_EN
        checks++;
        if ({q_first, q_last} !== 2'b00) begin
            errors++;
            $display("FAIL r4_idle_first_last got %b expected 00", {q_first, q_last});
        end
`endif
    endtask

    task automatic test_backpressure();
        cyc();
        d_v_i = 1'b1;
        d_data_i = 16'hBEEF;
        d_ready_i = 1'b0;
        d_q.push_back(8'hEF);
        d_q.push_back(8'hBE);
        cyc();
        d_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({d_data_o, d_v_o, d_ready_o} !== {8'hEF, 2'b10}) begin
                errors++;
                $display("FAIL stall%0d data,v_o,ready_o got %h,%b,%b expected ef,1,0",
                         k, d_data_o, d_v_o, d_ready_o);
            end
            cyc();
        end
        d_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (d_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release ready_o got %b expected 0", d_ready_o);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (d_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_last ready_o got %b expected 1", d_ready_o);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (d_v_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle v_o got %b expected 0", d_v_o);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        l_v_i = 1'b1;
        l_data_i = 32'hDEADBEEF;
        l_q.push_back(8'hEF);
        cyc();
        l_v_i = 1'b0;
        cyc();
        reset_i = 1'b1;
        #1;
        checks++;
        if ({l_v_o, l_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL midreset v_o,ready_o got %b expected 01", {l_v_o, l_ready_o});
        end
        cyc();
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({l_v_o, l_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset v_o,ready_o got %b expected 01", {l_v_o, l_ready_o});
        end
        cyc();
        l_v_i = 1'b1;
        l_data_i = 32'h00000011;
        l_q.push_back(8'h11);
        l_q.push_back(8'h00);
        l_q.push_back(8'h00);
        l_q.push_back(8'h00);
        cyc();
        l_v_i = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        checks++;
        if (l_v_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle v_o got %b expected 0", l_v_o);
        end
    endtask

    task automatic test_drain();
        repeat (2) cyc();
        checks++;
        if (d_q.size() + q_q.size() + l_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending beats got %0d expected 0",
                     d_q.size() + q_q.size() + l_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ratio4_msb();
        test_backpressure();
        test_reset_mid();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
